md_unit: RTL

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_unit.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with architectural HI/LO registers.
// Define MD_UNIT_MADD_EN to add the madd/maddu/msub/msubu accumulate ops (codes 1000-1011).
module md_unit #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       MDCtrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] out
);

  localparam int W2 = 2 * WIDTH;

  localparam logic [3:0] OP_MULT  = 4'b0000;
  localparam logic [3:0] OP_MULTU = 4'b0001;
  localparam logic [3:0] OP_DIV   = 4'b0010;
  localparam logic [3:0] OP_DIVU  = 4'b0011;
  localparam logic [3:0] OP_MFHI  = 4'b0100;
  localparam logic [3:0] OP_MTHI  = 4'b0110;
  localparam logic [3:0] OP_MTLO  = 4'b0111;
`ifdef MD_UNIT_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'b1000;
  localparam logic [3:0] OP_MADDU = 4'b1001;
  localparam logic [3:0] OP_MSUB  = 4'b1010;
  localparam logic [3:0] OP_MSUBU = 4'b1011;
`endif

  localparam logic [3:0]       MULT_CNT = 4'(MULT_LAT);
  localparam logic [3:0]       DIV_CNT  = 4'(DIV_LAT);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  logic                    is_mul, is_div, launch;
  logic                    div_zero, div_ovf;
  logic [WIDTH-1:0]        b_safe_s, b_safe_u;
  logic signed [W2-1:0]    prod_s;
  logic [W2-1:0]           prod_u;
  logic signed [WIDTH-1:0] quot_s, rem_s;
  logic [WIDTH-1:0]        quot_u, rem_u;

  always_comb begin
    is_mul = (MDCtrl == OP_MULT) || (MDCtrl == OP_MULTU);
`ifdef MD_UNIT_MADD_EN
    is_mul = is_mul || (MDCtrl[3:2] == 2'b10);
`endif
    is_div = (MDCtrl == OP_DIV) || (MDCtrl == OP_DIVU);
  end

  assign launch = (state_q == S_IDLE) && start && (is_mul || is_div);

  // Divisor is steered to 1 for the zero and overflow cases so the divider never
  // sees an undefined operation; those results are discarded at commit anyway.
  assign div_zero = (b_q == '0);
  assign div_ovf  = (a_q == MOST_NEG) && (b_q == '1);
  assign b_safe_s = (div_zero || div_ovf) ? ONE : b_q;
  assign b_safe_u = div_zero ? ONE : b_q;

  assign prod_s = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
  assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
  assign quot_s = $signed(a_q) / $signed(b_safe_s);
  assign rem_s  = $signed(a_q) % $signed(b_safe_s);
  assign quot_u = a_q / b_safe_u;
  assign rem_u  = a_q % b_safe_u;

  // NOTE: every signal written here gets a default first, otherwise paths that skip
  // an assignment would infer latches.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (launch) begin
          state_d = S_BUSY;
          cnt_d   = is_mul ? MULT_CNT : DIV_CNT;
          op_d    = MDCtrl;
          a_d     = A;
          b_d     = B;
        end else if (MDCtrl == OP_MTHI) begin
          hi_d = A;
        end else if (MDCtrl == OP_MTLO) begin
          lo_d = A;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
          case (op_q)
            OP_MULT:  {hi_d, lo_d} = $unsigned(prod_s);
            OP_MULTU: {hi_d, lo_d} = prod_u;
            OP_DIV: begin
              if (div_ovf) begin
                lo_d = MOST_NEG;
                hi_d = '0;
              end else if (!div_zero) begin
                lo_d = $unsigned(quot_s);
                hi_d = $unsigned(rem_s);
              end
            end
            OP_DIVU: begin
              if (!div_zero) begin
                lo_d = quot_u;
                hi_d = rem_u;
              end
            end
`ifdef MD_UNIT_MADD_EN
            OP_MADD:  {hi_d, lo_d} = {hi_q, lo_q} + $unsigned(prod_s);
            OP_MADDU: {hi_d, lo_d} = {hi_q, lo_q} + prod_u;
            OP_MSUB:  {hi_d, lo_d} = {hi_q, lo_q} - $unsigned(prod_s);
            OP_MSUBU: {hi_d, lo_d} = {hi_q, lo_q} - prod_u;
`endif
            default: ;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy  = (state_q == S_BUSY);
  assign stall = busy | start;
  assign HI    = hi_q;
  assign LO    = lo_q;
  assign out   = (MDCtrl == OP_MFHI) ? hi_q : lo_q;

endmodule
